warp_issue_sched: RTL and testbench
===================================

Name: warp_issue_sched

Overview:
- Per-core warp scheduler, next generation of the fetch-stage warp selector.
- Sits between warp-control/decode/branch feedback and the icache fetch request.
- Holds per-warp PC, thread mask, activity, stall and barrier state.
- Generalised over the previous selector:
  - parametrised warp/thread/barrier counts;
  - selectable arbitration policy (rotating round-robin or greedy-then-oldest);
  - up to MAX_INFLIGHT outstanding fetches per warp via credit counters (replaces the single-bit fetch lock);
  - per-warp epoch tag so wrong-path fetches can be discarded after a taken branch.

Parameters:
- NUM_WARPS, 4, warps per core (power of 2, ≥2); NW = log2(NUM_WARPS).
- NUM_THREADS, 4, threads per warp.
- NUM_BARRIERS, 4, hardware barriers; NB = max(1, log2(NUM_BARRIERS)).
- MAX_INFLIGHT, 2, max outstanding fetches per warp (≥1).
- POLICY, 0, 0 = rotating round-robin, 1 = greedy-then-oldest (GTO).
- STARTUP_ADDR, 32'h80000000, reset PC of warp 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- tmc_valid  in  1  thread-mask change for tmc_wid
- tmc_wid  in  NW  target warp
- tmc_tmask  in  NUM_THREADS  new thread mask
- wspawn_valid  in  1  warp spawn
- wspawn_wmask  in  NUM_WARPS  warps to activate
- wspawn_pc  in  32  start PC for spawned warps
- bar_valid  in  1  barrier arrival
- bar_wid  in  NW  arriving warp
- bar_id  in  NB  barrier index
- bar_size_m1  in  NW  expected warp count minus 1
- stall_valid  in  1  decode saw a control instruction
- stall_wid  in  NW  warp to stall
- br_valid  in  1  branch resolved
- br_wid  in  NW  branch warp
- br_taken  in  1  branch taken
- br_dest  in  32  branch target
- req_valid  out  1  fetch request valid
- req_ready  in  1  fetch request accepted
- req_wid  out  NW  warp id
- req_pc  out  32  fetch PC
- req_tmask  out  NUM_THREADS  thread mask
- req_epoch  out  1  epoch of the issuing warp
- rsp_valid  in  1  fetch response returned (returns one credit)
- rsp_wid  in  NW  response warp
- rsp_epoch  in  1  epoch carried with the response
- rsp_stale  out  1  combinational: rsp_epoch != epoch[rsp_wid]; consumer drops the response
- busy  out  1  |active

Behaviour:
- Reset values:
  - warp 0: active, PC = STARTUP_ADDR, tmask = 1.
  - Other warps: inactive, PC 0, tmask 0.
  - All credits, stalls, epochs and barrier masks 0; RR pointer 0.
  - req_valid 0, req_* 0, busy 1.
- Eligibility: eligible[w] = active & ~stalled & ~barrier_wait & (credit < MAX_INFLIGHT).
  - Uses registered state only, so an event at cycle N affects selection at N+1.
- Issue:
  - One output register.
  - Load when !req_valid or req_ready; select one eligible warp per load.
  - Issue = load & any eligible.
  - On issue: credit[w]++, pc[w] += 4; req_pc = pre-increment PC.
  - req_valid & !req_ready: hold all req_* stable; no selection.
- Policy 0 (round-robin): search eligible warps starting at ptr; after an issue, ptr = winner + 1 mod NUM_WARPS.
- Policy 1 (GTO): reissue the last issued warp while it is eligible, otherwise choose the lowest eligible index.
- Credits:
  - rsp_valid decrements credit[rsp_wid]; stale responses also return credit.
  - Issue and response on the same warp in the same cycle: net unchanged.
  - Never underflows (assert).
- Branch: br_valid clears stalled[br_wid].
  - If taken: pc = br_dest and epoch toggles.
  - Branch write to pc beats the +4 from a same-cycle issue.
- stall_valid sets stalled[stall_wid]. On the same warp in the same cycle, a set beats any clear (branch/tmc/barrier).
- tmc: tmask[wid] = tmc_tmask; active[wid] = (tmask != 0); clears stalled[wid].
- wspawn:
  - For each w≠0 with wmask[w]: active = 1, pc = wspawn_pc, tmask = 1, credit 0, epoch unchanged.
  - Warp 0 is unaffected.
  - tmc on the same wid in the same cycle wins.
- Barrier:
  - count = popcount(mask[bar_id]).
  - If count == bar_size_m1: mask[bar_id] = 0, releasing all waiters.
  - Else: set mask[bar_id][bar_wid].
  - Always clears stalled[bar_wid].
  - barrier_wait[w] = OR over all barrier masks.
- Deactivated warps with credit > 0 keep credit until responses drain.
- busy ignores credits.
- Reset mid-operation discards the held request and all credits; late responses after reset are a bench error.

Decomposition:
- Shared package: policy enum (POLICY_RR, POLICY_GTO), the NW/NB width helpers, and a per-warp state struct {active, stalled, epoch, credit, pc, tmask}.
- One sub-module: warp_issue_arbiter, a combinational-plus-pointer picker implementing both policies; it takes eligible and last_wid and returns valid and wid.

Test Plan:
- Reset, req_ready=1 -> first req: wid 0, pc 0x80000000, tmask 1; next req pc 0x80000004; third request held until rsp_valid (MAX_INFLIGHT=2).
- wspawn wmask=4'b1111, pc 0x100, POLICY 0, responses returned promptly -> issue order 0,1,2,3,0…; warps 1–3 start at pc 0x100, tmask 1.
- Same spawn with POLICY 1 and warp 0 always eligible -> warp 0 only; stall warp 0 -> warp 1 issues next cycle.
- Warp 2 stall, then br taken dest 0x200 -> next warp-2 req pc 0x200 with epoch flipped; in-flight old response -> rsp_stale=1 and credit returned.
- 4 warps, bar_size_m1=3, arrivals from warps 0,1,2 -> those three are excluded from issue; arrival from warp 3 -> mask cleared, all four eligible next cycle.
- tmc tmask=0 on every active warp -> busy falls to 0 and req_valid stays 0; req_ready=0 for 5 cycles mid-stream -> req fields stable.

Source files
------------

// File: rtl/warp_issue_sched_pkg.sv
// Shared definitions for the warp issue scheduler.
//   policy_e      : arbitration policy selector (rotating RR or greedy-then-oldest)
//   idx_width()   : index width helper, never narrower than one bit
//   warp_state_t  : per-warp architectural state. tmask and credit use fixed
//                   maximum widths; the top only drives and reads the low bits
//                   it needs, so the struct stays independent of parameters.
package warp_issue_sched_pkg;

  typedef enum logic {
    POLICY_RR  = 1'b0,
    POLICY_GTO = 1'b1
  } policy_e;

  localparam int MAX_THREADS = 32;
  localparam int CREDIT_W    = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                   active;
    logic                   stalled;
    logic                   epoch;
    logic [CREDIT_W-1:0]    credit;
    logic [31:0]            pc;
    logic [MAX_THREADS-1:0] tmask;
  } warp_state_t;

endpackage

// File: rtl/warp_issue_arbiter.sv
// Warp picker for the issue stage.
//   clk, reset  : clock, synchronous active-high reset (clears the RR pointer)
//   eligible_i  : per-warp eligibility, from registered scheduler state
//   last_wid_i  : most recently issued warp (used by GTO)
//   issue_i     : the current pick is being issued this cycle
//   valid_o     : at least one warp is eligible
//   wid_o       : selected warp
// RR searches upward from a rotating pointer that moves past each winner.
// GTO sticks with the last issued warp while it stays eligible, otherwise
// falls back to the lowest eligible index.
module warp_issue_arbiter
  import warp_issue_sched_pkg::*;
#(
  parameter int      NUM_WARPS = 4,
  parameter policy_e POLICY    = POLICY_RR,
  localparam int     NW        = idx_width(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_WARPS-1:0] eligible_i,
  input  logic [NW-1:0]        last_wid_i,
  input  logic                 issue_i,
  output logic                 valid_o,
  output logic [NW-1:0]        wid_o
);

  logic [NW-1:0] ptr_q;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise the tool infers a latch.
  always_comb begin
    valid_o = 1'b0;
    wid_o   = '0;
    if (POLICY == POLICY_GTO) begin
      if (eligible_i[last_wid_i]) begin
        valid_o = 1'b1;
        wid_o   = last_wid_i;
      end else begin
        // Descending scan: the lowest eligible index is the last one written.
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
          if (eligible_i[i]) begin
            valid_o = 1'b1;
            wid_o   = NW'(i);
          end
        end
      end
    end else begin
      // Offsets wrap naturally because NUM_WARPS is a power of two.
      for (int i = NUM_WARPS - 1; i >= 0; i--) begin
        if (eligible_i[ptr_q + NW'(i)]) begin
          valid_o = 1'b1;
          wid_o   = ptr_q + NW'(i);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (issue_i) begin
      ptr_q <= wid_o + NW'(1);
    end
  end

endmodule

// File: rtl/warp_issue_sched.sv
// Per-core warp scheduler feeding the icache fetch request.
//   clk, reset          : clock, synchronous active-high reset
//   tmc_*               : thread-mask change; an all-zero mask deactivates the warp
//   wspawn_*            : activate warps 1..N-1 selected by wmask at wspawn_pc
//   bar_*               : barrier arrival; last expected arrival releases all waiters
//   stall_*             : decode saw a control instruction, stop fetching that warp
//   br_*                : branch resolved; unstalls, redirects and bumps epoch if taken
//   req_* / req_ready   : registered fetch request with valid/ready handshake
//   rsp_* / rsp_stale   : fetch response returns a credit; stale if epoch moved on
//   busy                : any warp active (outstanding credits are ignored)
module warp_issue_sched
  import warp_issue_sched_pkg::*;
#(
  parameter int          NUM_WARPS    = 4,
  parameter int          NUM_THREADS  = 4,
  parameter int          NUM_BARRIERS = 4,
  parameter int          MAX_INFLIGHT = 2,
  parameter int          POLICY       = 0,
  parameter logic [31:0] STARTUP_ADDR = 32'h8000_0000,
  localparam int         NW           = idx_width(NUM_WARPS),
  localparam int         NB           = idx_width(NUM_BARRIERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tmc_valid,
  input  logic [NW-1:0]          tmc_wid,
  input  logic [NUM_THREADS-1:0] tmc_tmask,
  input  logic                   wspawn_valid,
  input  logic [NUM_WARPS-1:0]   wspawn_wmask,
  input  logic [31:0]            wspawn_pc,
  input  logic                   bar_valid,
  input  logic [NW-1:0]          bar_wid,
  input  logic [NB-1:0]          bar_id,
  input  logic [NW-1:0]          bar_size_m1,
  input  logic                   stall_valid,
  input  logic [NW-1:0]          stall_wid,
  input  logic                   br_valid,
  input  logic [NW-1:0]          br_wid,
  input  logic                   br_taken,
  input  logic [31:0]            br_dest,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [NW-1:0]          req_wid,
  output logic [31:0]            req_pc,
  output logic [NUM_THREADS-1:0] req_tmask,
  output logic                   req_epoch,
  input  logic                   rsp_valid,
  input  logic [NW-1:0]          rsp_wid,
  input  logic                   rsp_epoch,
  output logic                   rsp_stale,
  output logic                   busy
);

  localparam policy_e POLICY_SEL = (POLICY == 1) ? POLICY_GTO : POLICY_RR;

  warp_state_t            ws_q       [NUM_WARPS];
  warp_state_t            ws_d       [NUM_WARPS];
  logic [NUM_WARPS-1:0]   bar_mask_q [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]   bar_mask_d [NUM_BARRIERS];

  logic                   req_valid_q;
  logic [NW-1:0]          req_wid_q;
  logic [31:0]            req_pc_q;
  logic [NUM_THREADS-1:0] req_tmask_q;
  logic                   req_epoch_q;
  logic [NW-1:0]          last_wid_q;

  logic [NUM_WARPS-1:0]   eligible;
  logic [NUM_WARPS-1:0]   barrier_wait;
  logic [NUM_WARPS-1:0]   active;
  logic [NW:0]            bar_count;
  logic                   arb_valid;
  logic [NW-1:0]          arb_wid;
  logic                   load;
  logic                   issue;

  // Eligibility looks at registered state only, so any event lands one
  // cycle before it can influence selection.
  always_comb begin
    barrier_wait = '0;
    active       = '0;
    eligible     = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        barrier_wait[w] = barrier_wait[w] | bar_mask_q[b][w];
      end
      active[w]   = ws_q[w].active;
      eligible[w] = ws_q[w].active & ~ws_q[w].stalled & ~barrier_wait[w]
                  & (ws_q[w].credit < CREDIT_W'(MAX_INFLIGHT));
    end
  end

  warp_issue_arbiter #(
    .NUM_WARPS (NUM_WARPS),
    .POLICY    (POLICY_SEL)
  ) u_arbiter (
    .clk        (clk),
    .reset      (reset),
    .eligible_i (eligible),
    .last_wid_i (last_wid_q),
    .issue_i    (issue),
    .valid_o    (arb_valid),
    .wid_o      (arb_wid)
  );

  // A stalled output register holds everything and suppresses selection.
  assign load  = !req_valid_q || req_ready;
  assign issue = load && arb_valid;

  always_comb begin
    bar_count = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      bar_count = bar_count + (NW+1)'(bar_mask_q[bar_id][w]);
    end
  end

  // Updates are applied in priority order: later statements win on the
  // same warp (branch PC over +4, tmc over spawn, stall set over any clear).
  always_comb begin
    ws_d       = ws_q;
    bar_mask_d = bar_mask_q;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (issue && arb_wid == NW'(w)) begin
        ws_d[w].credit = ws_d[w].credit + CREDIT_W'(1);
        ws_d[w].pc     = ws_d[w].pc + 32'd4;
      end
      if (rsp_valid && rsp_wid == NW'(w)) begin
        ws_d[w].credit = ws_d[w].credit - CREDIT_W'(1);
      end
      if (wspawn_valid && wspawn_wmask[w] && w != 0) begin
        ws_d[w].active = 1'b1;
        ws_d[w].pc     = wspawn_pc;
        ws_d[w].tmask  = MAX_THREADS'(1);
        ws_d[w].credit = '0;
      end
      if (tmc_valid && tmc_wid == NW'(w)) begin
        ws_d[w].tmask   = MAX_THREADS'(tmc_tmask);
        ws_d[w].active  = |tmc_tmask;
        ws_d[w].stalled = 1'b0;
      end
      if (bar_valid && bar_wid == NW'(w)) begin
        ws_d[w].stalled = 1'b0;
      end
      if (br_valid && br_wid == NW'(w)) begin
        ws_d[w].stalled = 1'b0;
        if (br_taken) begin
          ws_d[w].pc    = br_dest;
          ws_d[w].epoch = ~ws_q[w].epoch;
        end
      end
      if (stall_valid && stall_wid == NW'(w)) begin
        ws_d[w].stalled = 1'b1;
      end
    end
    if (bar_valid) begin
      if (bar_count == {1'b0, bar_size_m1}) begin
        bar_mask_d[bar_id] = '0;
      end else begin
        bar_mask_d[bar_id][bar_wid] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the per-warp state arrays are architecturally visible (PC,
      // activity, credits), so every entry is reset, not just the control flops.
      for (int w = 0; w < NUM_WARPS; w++) begin
        ws_q[w] <= '0;
      end
      ws_q[0].active <= 1'b1;
      ws_q[0].pc     <= STARTUP_ADDR;
      ws_q[0].tmask  <= MAX_THREADS'(1);
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        bar_mask_q[b] <= '0;
      end
      req_valid_q <= 1'b0;
      req_wid_q   <= '0;
      req_pc_q    <= '0;
      req_tmask_q <= '0;
      req_epoch_q <= 1'b0;
      last_wid_q  <= '0;
    end else begin
      assert (!rsp_valid || ws_q[rsp_wid].credit != '0);
      ws_q       <= ws_d;
      bar_mask_q <= bar_mask_d;
      if (load) begin
        req_valid_q <= arb_valid;
        if (arb_valid) begin
          req_wid_q   <= arb_wid;
          req_pc_q    <= ws_q[arb_wid].pc;
          req_tmask_q <= ws_q[arb_wid].tmask[NUM_THREADS-1:0];
          req_epoch_q <= ws_q[arb_wid].epoch;
          last_wid_q  <= arb_wid;
        end
      end
    end
  end

  assign req_valid = req_valid_q;
  assign req_wid   = req_wid_q;
  assign req_pc    = req_pc_q;
  assign req_tmask = req_tmask_q;
  assign req_epoch = req_epoch_q;
  assign rsp_stale = rsp_epoch != ws_q[rsp_wid].epoch;
  assign busy      = |active;

endmodule

// File: tb/tb_warp_issue_sched.sv
// Directed bench for warp_issue_sched: one round-robin and one GTO instance
// sharing control inputs; only one is out of reset at a time.
module tb_warp_issue_sched;

  localparam int NW = 2;
  localparam int NB = 2;
  localparam int NT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, reset_g;
  logic          tmc_valid;
  logic [NW-1:0] tmc_wid;
  logic [NT-1:0] tmc_tmask;
  logic          wspawn_valid;
  logic [3:0]    wspawn_wmask;
  logic [31:0]   wspawn_pc;
  logic          bar_valid;
  logic [NW-1:0] bar_wid;
  logic [NB-1:0] bar_id;
  logic [NW-1:0] bar_size_m1;
  logic          stall_valid;
  logic [NW-1:0] stall_wid;
  logic          br_valid;
  logic [NW-1:0] br_wid;
  logic          br_taken;
  logic [31:0]   br_dest;

  logic          req_ready, req_valid, req_epoch, rsp_valid, rsp_epoch, rsp_stale, busy;
  logic [NW-1:0] req_wid, rsp_wid;
  logic [31:0]   req_pc;
  logic [NT-1:0] req_tmask;

  logic          req_ready_g, req_valid_g, req_epoch_g, rsp_valid_g, rsp_epoch_g, rsp_stale_g, busy_g;
  logic [NW-1:0] req_wid_g, rsp_wid_g;
  logic [31:0]   req_pc_g;
  logic [NT-1:0] req_tmask_g;

  int checks   = 0;
  int failures = 0;

  warp_issue_sched #(.POLICY(0)) dut_rr (
    .clk(clk), .reset(reset),
    .tmc_valid(tmc_valid), .tmc_wid(tmc_wid), .tmc_tmask(tmc_tmask),
    .wspawn_valid(wspawn_valid), .wspawn_wmask(wspawn_wmask), .wspawn_pc(wspawn_pc),
    .bar_valid(bar_valid), .bar_wid(bar_wid), .bar_id(bar_id), .bar_size_m1(bar_size_m1),
    .stall_valid(stall_valid), .stall_wid(stall_wid),
    .br_valid(br_valid), .br_wid(br_wid), .br_taken(br_taken), .br_dest(br_dest),
    .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid), .req_pc(req_pc),
    .req_tmask(req_tmask), .req_epoch(req_epoch),
    .rsp_valid(rsp_valid), .rsp_wid(rsp_wid), .rsp_epoch(rsp_epoch), .rsp_stale(rsp_stale),
    .busy(busy)
  );

  warp_issue_sched #(.POLICY(1)) dut_gto (
    .clk(clk), .reset(reset_g),
    .tmc_valid(tmc_valid), .tmc_wid(tmc_wid), .tmc_tmask(tmc_tmask),
    .wspawn_valid(wspawn_valid), .wspawn_wmask(wspawn_wmask), .wspawn_pc(wspawn_pc),
    .bar_valid(bar_valid), .bar_wid(bar_wid), .bar_id(bar_id), .bar_size_m1(bar_size_m1),
    .stall_valid(stall_valid), .stall_wid(stall_wid),
    .br_valid(br_valid), .br_wid(br_wid), .br_taken(br_taken), .br_dest(br_dest),
    .req_valid(req_valid_g), .req_ready(req_ready_g), .req_wid(req_wid_g), .req_pc(req_pc_g),
    .req_tmask(req_tmask_g), .req_epoch(req_epoch_g),
    .rsp_valid(rsp_valid_g), .rsp_wid(rsp_wid_g), .rsp_epoch(rsp_epoch_g), .rsp_stale(rsp_stale_g),
    .busy(busy_g)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic expect_req(input string tag, input logic [NW-1:0] wid, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(req_valid), 32'd1);
    check({tag, "_wid"},   32'(req_wid),   32'(wid));
    check({tag, "_pc"},    req_pc,         pc);
  endtask

  task automatic expect_req_g(input string tag, input logic [NW-1:0] wid, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(req_valid_g), 32'd1);
    check({tag, "_wid"},   32'(req_wid_g),   32'(wid));
    check({tag, "_pc"},    req_pc_g,         pc);
  endtask

  // Return the response for the request on the bus, at the edge that accepts it.
  task automatic auto_rsp();
    rsp_valid = req_valid;
    rsp_wid   = req_wid;
    rsp_epoch = req_epoch;
  endtask

  task automatic auto_rsp_g();
    rsp_valid_g = req_valid_g;
    rsp_wid_g   = req_wid_g;
    rsp_epoch_g = req_epoch_g;
  endtask

  task automatic idle_ctrl();
    tmc_valid = 1'b0; tmc_wid = '0; tmc_tmask = '0;
    wspawn_valid = 1'b0; wspawn_wmask = '0; wspawn_pc = '0;
    bar_valid = 1'b0; bar_wid = '0; bar_id = '0; bar_size_m1 = '0;
    stall_valid = 1'b0; stall_wid = '0;
    br_valid = 1'b0; br_wid = '0; br_taken = 1'b0; br_dest = '0;
  endtask

  task automatic spawn_all();
    wspawn_valid = 1'b1;
    wspawn_wmask = 4'b1111;
    wspawn_pc    = 32'h100;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [NW-1:0] ew;
    logic [31:0]   ep;

    reset = 1'b1; reset_g = 1'b1;
    idle_ctrl();
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_wid = '0; rsp_epoch = 1'b0;
    req_ready_g = 1'b0; rsp_valid_g = 1'b0; rsp_wid_g = '0; rsp_epoch_g = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_req_wid",   32'(req_wid),   32'd0);
    check("rst_req_pc",    req_pc,         32'd0);
    check("rst_req_tmask", 32'(req_tmask), 32'd0);
    check("rst_busy",      32'(busy),      32'd1);

    // Warp 0 alone: two requests, then blocked by credits until a response
    reset = 1'b0; req_ready = 1'b1;
    tick();
    expect_req("p1_r0", 2'd0, 32'h8000_0000);
    check("p1_r0_tmask", 32'(req_tmask), 32'd1);
    tick();
    expect_req("p1_r1", 2'd0, 32'h8000_0004);
    tick();
    check("p1_credit_block0", 32'(req_valid), 32'd0);
    tick();
    check("p1_credit_block1", 32'(req_valid), 32'd0);
    rsp_valid = 1'b1; rsp_wid = 2'd0; rsp_epoch = 1'b0;
    #1;
    check("p1_rsp_fresh", 32'(rsp_stale), 32'd0);
    tick();
    rsp_valid = 1'b0;
    check("p1_after_rsp_edge", 32'(req_valid), 32'd0);
    tick();
    expect_req("p1_r2", 2'd0, 32'h8000_0008);

    // Round-robin over four spawned warps with prompt responses
    reset = 1'b1; tick();
    reset = 1'b0; spawn_all();
    for (int i = 0; i < 8; i++) begin
      tick();
      wspawn_valid = 1'b0;
      ew = NW'(i % 4);
      ep = (i % 4 == 0) ? 32'h8000_0000 + 32'(4 * (i / 4)) : 32'h100 + 32'(4 * (i / 4));
      expect_req($sformatf("rr%0d", i), ew, ep);
      check($sformatf("rr%0d_tmask", i), 32'(req_tmask), 32'd1);
      auto_rsp();
    end
    // Back-pressure: request must stay frozen
    rsp_valid = 1'b0; req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_req($sformatf("hold%0d", k), 2'd3, 32'h104);
    end
    req_ready = 1'b1;
    tick();
    expect_req("rr8", 2'd0, 32'h8000_0008);

    // GTO: warp 0 monopolises until stalled
    rsp_valid = 1'b0; reset = 1'b1; reset_g = 1'b0; req_ready_g = 1'b1;
    spawn_all();
    for (int i = 0; i < 6; i++) begin
      tick();
      wspawn_valid = 1'b0;
      expect_req_g($sformatf("gto%0d", i), 2'd0, 32'h8000_0000 + 32'(4 * i));
      auto_rsp_g();
    end
    stall_valid = 1'b1; stall_wid = 2'd0;
    tick();
    stall_valid = 1'b0;
    expect_req_g("gto6", 2'd0, 32'h8000_0018);
    auto_rsp_g();
    tick();
    expect_req_g("gto_stall_sw", 2'd1, 32'h100);
    auto_rsp_g();
    tick();
    expect_req_g("gto_stick", 2'd1, 32'h104);

    // Branch redirect with epoch flip and stale response credit return
    rsp_valid_g = 1'b0; reset_g = 1'b1; idle_ctrl();
    tick();
    reset = 1'b0; req_ready = 1'b1; spawn_all();
    tick(); wspawn_valid = 1'b0;
    expect_req("br_e1", 2'd0, 32'h8000_0000); auto_rsp();
    tick();
    expect_req("br_e2", 2'd1, 32'h100); auto_rsp();
    tick();
    expect_req("br_e3", 2'd2, 32'h100);
    check("br_e3_epoch", 32'(req_epoch), 32'd0);
    rsp_valid = 1'b0; stall_valid = 1'b1; stall_wid = 2'd2;
    tick();
    stall_valid = 1'b0;
    expect_req("br_e4", 2'd3, 32'h100); auto_rsp();
    br_valid = 1'b1; br_wid = 2'd2; br_taken = 1'b1; br_dest = 32'h200;
    tick();
    br_valid = 1'b0;
    expect_req("br_e5", 2'd0, 32'h8000_0004); auto_rsp();
    tick();
    expect_req("br_e6", 2'd1, 32'h104); auto_rsp();
    tick();
    expect_req("br_e7", 2'd2, 32'h200);
    check("br_e7_epoch", 32'(req_epoch), 32'd1);
    rsp_valid = 1'b1; rsp_wid = 2'd2; rsp_epoch = 1'b0;
    #1;
    check("br_stale", 32'(rsp_stale), 32'd1);
    tick();
    expect_req("br_e8", 2'd3, 32'h104); auto_rsp();
    tick();
    expect_req("br_e9", 2'd0, 32'h8000_0008); auto_rsp();
    tick();
    expect_req("br_e10", 2'd1, 32'h108); auto_rsp();
    tick();
    expect_req("br_credit_back", 2'd2, 32'h204);
    rsp_valid = 1'b1; rsp_wid = 2'd2; rsp_epoch = 1'b1;
    #1;
    check("br_fresh", 32'(rsp_stale), 32'd0);

    // Barrier: warps 0..2 wait until warp 3 arrives
    rsp_valid = 1'b0; reset = 1'b1; idle_ctrl();
    tick();
    reset = 1'b0; spawn_all(); bar_id = 2'd1; bar_size_m1 = 2'd3;
    tick(); wspawn_valid = 1'b0;
    expect_req("bar_e1", 2'd0, 32'h8000_0000); auto_rsp();
    bar_valid = 1'b1; bar_wid = 2'd0;
    tick();
    expect_req("bar_e2", 2'd1, 32'h100); auto_rsp(); bar_wid = 2'd1;
    tick();
    expect_req("bar_e3", 2'd2, 32'h100); auto_rsp(); bar_wid = 2'd2;
    tick();
    expect_req("bar_e4", 2'd3, 32'h100); auto_rsp(); bar_valid = 1'b0;
    tick();
    expect_req("bar_e5", 2'd3, 32'h104); auto_rsp();
    tick();
    expect_req("bar_e6", 2'd3, 32'h108); auto_rsp();
    bar_valid = 1'b1; bar_wid = 2'd3;
    tick();
    bar_valid = 1'b0;
    expect_req("bar_e7", 2'd3, 32'h10C); auto_rsp();
    tick();
    expect_req("bar_rel0", 2'd0, 32'h8000_0004); auto_rsp();
    tick();
    expect_req("bar_rel1", 2'd1, 32'h104); auto_rsp();
    tick();
    expect_req("bar_rel2", 2'd2, 32'h104);

    // tmc to zero on every warp drains the scheduler
    rsp_valid = 1'b0; reset = 1'b1; idle_ctrl();
    tick();
    reset = 1'b0; spawn_all();
    tick(); wspawn_valid = 1'b0; auto_rsp();
    for (int k = 0; k < 3; k++) begin
      tick(); auto_rsp();
    end
    tmc_valid = 1'b1; tmc_tmask = '0;
    for (int w = 0; w < 4; w++) begin
      tmc_wid = NW'(w);
      tick(); auto_rsp();
    end
    tmc_valid = 1'b0;
    check("tmc_busy_low", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(); auto_rsp();
      check($sformatf("tmc_idle%0d_valid", k), 32'(req_valid), 32'd0);
      check($sformatf("tmc_idle%0d_busy", k),  32'(busy),      32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
